// File: rtl/control_unit_mc.sv
// Multicycle Moore control unit for the 16-bit RISC datapath: fetch/decode/execute
// sequencing with memory wait states, conditional branch, halt and illegal-opcode trap.
module control_unit_mc #(
  parameter int                 INSTR_W  = 16,
  parameter int                 OPC_W    = 4,
  parameter int                 RADDR_W  = 4,
  parameter logic [RADDR_W-1:0] PC_IDX   = {RADDR_W{1'b1}},
  parameter int                 MEM_WAIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               mem_ready,
  input  logic               alu_zero,
  output logic               anop,
  output logic               aop,
  output logic               reg_r,
  output logic               reg_w,
  output logic               t1oe,
  output logic               t1ce,
  output logic               t2oe,
  output logic               t2ce,
  output logic               pcoe,
  output logic               c1oe,
  output logic               marce,
  output logic               maroe,
  output logic               mdrce,
  output logic               mdroe,
  output logic               mdrput,
  output logic               mdrget,
  output logic               mem_read,
  output logic               mem_write,
  output logic               irce,
  output logic [2:0]         opr_sel,
  output logic [RADDR_W-1:0] reg_addr_bus,
  output logic               halted,
  output logic               trap,
  output logic [3:0]         state_dbg
);

  typedef enum logic [3:0] {
    ST_F0 = 4'd0, ST_F1 = 4'd1, ST_F2 = 4'd2, ST_D0 = 4'd3,
    ST_E0 = 4'd4, ST_E1 = 4'd5, ST_E2 = 4'd6, ST_E3 = 4'd7,
    ST_E4 = 4'd8, ST_E5 = 4'd9, ST_E6 = 4'd10, ST_E7 = 4'd11,
    ST_BR0 = 4'd12, ST_BR1 = 4'd13, ST_BR2 = 4'd14, ST_HLT = 4'd15
  } state_t;

  state_t state_r;
  state_t next_s;
  logic   z_q;
  logic   trap_r;

  logic [OPC_W-1:0]   opc_s;
  logic [3:0]         op4_s;
  logic [RADDR_W-1:0] d_s;
  logic [RADDR_W-1:0] sx_s;
  logic [RADDR_W-1:0] sy_s;
  logic               illegal_s;
  logic               is_bz_s;
  logic               is_link_s;
  logic               is_load_s;
  logic               ready_s;
  logic [2:0]         alu_op_s;
  logic               dxw_s;
  logic               sxw_s;
  logic               syw_s;

  assign opc_s     = instruction[INSTR_W-1 -: OPC_W];
  assign op4_s     = opc_s[3:0];
  assign d_s       = instruction[3*RADDR_W-1 -: RADDR_W];
  assign sx_s      = instruction[2*RADDR_W-1 -: RADDR_W];
  assign sy_s      = instruction[RADDR_W-1:0];
  // Anything at or above 0xF (including the upper range of a wider opcode) traps
  assign illegal_s = (opc_s >= OPC_W'(4'hF));
  assign is_bz_s   = (op4_s == 4'hD);
  assign is_link_s = (op4_s == 4'hC);
  assign is_load_s = (op4_s == 4'hA);
  assign ready_s   = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  // ALU function for E1; 8 and 9 alias add and sub
  always_comb begin
    case (op4_s)
      4'h8:    alu_op_s = 3'b001;
      4'h9:    alu_op_s = 3'b010;
      default: alu_op_s = op4_s[2:0];
    endcase
  end

  // State register plus branch flag and trap flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_F0;
      z_q     <= 1'b0;
      trap_r  <= 1'b0;
    end else begin
      state_r <= next_s;
      if (state_r == ST_E1 && is_bz_s) z_q <= alu_zero;
      if (state_r == ST_D0 && illegal_s) trap_r <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_F0:  next_s = ST_F1;
      ST_F1:  if (ready_s) next_s = ST_F2; else next_s = ST_F1;
      ST_F2:  next_s = ST_D0;
      ST_D0: begin
        if (illegal_s) begin
          next_s = ST_HLT;
        end else begin
          case (op4_s)
            4'h0:                                           next_s = ST_F0;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hC, 4'hD: next_s = ST_E0;
            4'h6, 4'h7:                                     next_s = ST_E3;
            4'hA, 4'hB:                                     next_s = ST_E5;
            default:                                        next_s = ST_HLT;
          endcase
        end
      end
      ST_E0:  next_s = ST_E1;
      ST_E1: begin
        if (is_bz_s) next_s = alu_zero ? ST_BR0 : ST_F0;
        else         next_s = ST_E2;
      end
      ST_E2:  next_s = ST_F0;
      ST_E3:  next_s = ST_E4;
      ST_E4:  next_s = ST_E2;
      ST_E5:  next_s = ST_E6;
      ST_E6:  if (is_load_s && !ready_s) next_s = ST_E6; else next_s = ST_E7;
      ST_E7:  if (!is_load_s && !ready_s) next_s = ST_E7; else next_s = ST_F0;
      // BR0 is only reachable with z_q set; the guard keeps a corrupted state from branching
      ST_BR0: if (z_q) next_s = ST_BR1; else next_s = ST_F0;
      ST_BR1: next_s = ST_BR2;
      ST_BR2: next_s = ST_F0;
      ST_HLT: next_s = ST_HLT;
      default: next_s = ST_F0;
    endcase
  end

  // Moore strobe decode; everything forced low while reset is held
  always_comb begin
    anop = 1'b0; aop = 1'b0; reg_r = 1'b0; reg_w = 1'b0;
    t1oe = 1'b0; t1ce = 1'b0; t2oe = 1'b0; t2ce = 1'b0;
    pcoe = 1'b0; c1oe = 1'b0; marce = 1'b0; maroe = 1'b0;
    mdrce = 1'b0; mdroe = 1'b0; mdrput = 1'b0; mdrget = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; irce = 1'b0;
    opr_sel = 3'b000; halted = 1'b0; trap = 1'b0; state_dbg = 4'd0;
    dxw_s = 1'b0; sxw_s = 1'b0; syw_s = 1'b0;
    if (rst_n) begin
      state_dbg = state_r;
      case (state_r)
        ST_F0:  begin reg_r = 1'b1; pcoe = 1'b1; t1ce = 1'b1; marce = 1'b1; anop = 1'b1; end
        ST_F1:  begin
          aop = 1'b1; opr_sel = 3'b001; t1oe = 1'b1; c1oe = 1'b1; t2ce = 1'b1;
          maroe = 1'b1; mdrce = 1'b1; mem_read = 1'b1;
        end
        ST_F2:  begin anop = 1'b1; mdroe = 1'b1; mdrget = 1'b1; irce = 1'b1; end
        ST_D0:  begin reg_w = 1'b1; pcoe = 1'b1; t2oe = 1'b1; anop = 1'b1; end
        ST_E0:  begin
          reg_r = 1'b1; t1ce = 1'b1; anop = 1'b1;
          if (is_link_s) pcoe = 1'b1; else sxw_s = 1'b1;
        end
        ST_E1:  begin
          aop = 1'b1; t1oe = 1'b1; t2ce = 1'b1;
          if (is_link_s) begin
            c1oe = 1'b1; opr_sel = 3'b001;
          end else if (is_bz_s) begin
            opr_sel = 3'b000;
          end else begin
            reg_r = 1'b1; syw_s = 1'b1; opr_sel = alu_op_s;
          end
        end
        ST_E2:  begin reg_w = 1'b1; dxw_s = 1'b1; t2oe = 1'b1; anop = 1'b1; end
        ST_E3:  begin reg_r = 1'b1; sxw_s = 1'b1; t1ce = 1'b1; anop = 1'b1; end
        ST_E4:  begin
          t1oe = 1'b1; t2ce = 1'b1; aop = 1'b1;
          opr_sel = op4_s[0] ? 3'b111 : 3'b110;
        end
        ST_E5:  begin reg_r = 1'b1; sxw_s = 1'b1; marce = 1'b1; anop = 1'b1; end
        ST_E6:  begin
          anop = 1'b1; mdrce = 1'b1;
          if (is_load_s) begin maroe = 1'b1; mem_read = 1'b1; end
          else           begin reg_r = 1'b1; dxw_s = 1'b1; end
        end
        ST_E7:  begin
          anop = 1'b1;
          if (is_load_s) begin reg_w = 1'b1; dxw_s = 1'b1; mdroe = 1'b1; mdrget = 1'b1; end
          else           begin maroe = 1'b1; mdrput = 1'b1; mem_write = 1'b1; end
        end
        ST_BR0: begin reg_r = 1'b1; dxw_s = 1'b1; t1ce = 1'b1; anop = 1'b1; end
        ST_BR1: begin t1oe = 1'b1; t2ce = 1'b1; aop = 1'b1; opr_sel = 3'b000; end
        ST_BR2: begin reg_w = 1'b1; pcoe = 1'b1; t2oe = 1'b1; anop = 1'b1; end
        ST_HLT: begin halted = 1'b1; trap = trap_r; end
        default: begin halted = 1'b0; end
      endcase
    end else begin
      state_dbg = 4'd0;
    end
  end

  // Register address mux, PC output has priority
  always_comb begin
    if (pcoe)       reg_addr_bus = PC_IDX;
    else if (dxw_s) reg_addr_bus = d_s;
    else if (sxw_s) reg_addr_bus = sx_s;
    else if (syw_s) reg_addr_bus = sy_s;
    else            reg_addr_bus = {RADDR_W{1'b0}};
  end

endmodule
